display_scan_driver: RTL and testbench

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

---
 rtl/display_scan_driver_pkg.sv | 22 ++
 rtl/display_scan_driver_if.sv | 11 +
 rtl/display_shifter.sv | 92 +++++++++
 rtl/display_scan_driver.sv | 159 +++++++++++++++
 tb/tb_display_scan_driver.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/display_scan_driver_pkg.sv
// Shared types and default timing for the multiplexed display scan driver.
// Imported by the driver top and usable by any sibling block that needs the scan states.
package display_scan_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_SWAP
  } t_scan_state;

  localparam int C_DEF_COLUMNS    = 8;
  localparam int C_DEF_BITS       = 16;
  localparam int C_DEF_SCLK_HALF  = 2;
  localparam int C_DEF_COL_PERIOD = 256;
  localparam int C_SWAP_LEN       = 4;

  function automatic int shift_cycles(input int bits, input int sclk_half);
    return bits * 2 * sclk_half;
  endfunction

endpackage

// File: rtl/display_scan_driver_if.sv
// Column-driver pins: latch/blank strobes, column select and the serial clock/data pair.
interface t_display;
  logic       latch;
  logic       blank;
  logic [2:0] csel;
  logic       sclk;
  logic       sin;

  modport producer (output latch, blank, csel, sclk, sin);
  modport consumer (input  latch, blank, csel, sclk, sin);
endinterface

// File: rtl/display_shifter.sv
// Parallel-load serializer: MSB first, each bit is sclk low then high for G_SCLK_HALF cycles.
// Done_o is high in the final cycle of the last bit; Clear_i aborts a shift immediately.
module display_shifter #(
  parameter int G_BITS      = 16,
  parameter int G_SCLK_HALF = 2
) (
  input  logic              Clk_ik,
  input  logic              Rst_irn,
  input  logic              Clear_i,
  input  logic              Load_i,
  input  logic [G_BITS-1:0] Data_ib,
  output logic              Sclk_o,
  output logic              Sin_o,
  output logic              Done_o
);

  localparam int C_PH  = 2 * G_SCLK_HALF;
  localparam int C_PW  = $clog2(C_PH);
  localparam int C_BTW = (G_BITS > 1) ? $clog2(G_BITS) : 1;

  logic              busy_q, busy_d;
  logic [C_PW-1:0]   phase_q, phase_d;
  logic [C_BTW-1:0]  bit_q, bit_d;
  logic [G_BITS-1:0] sreg_q, sreg_d;
  logic              sclk_q, sclk_d;
  logic              sin_q, sin_d;
  logic              last_phase;

  assign last_phase = (phase_q == C_PW'(C_PH - 1));
  assign Done_o     = busy_q && last_phase && (bit_q == C_BTW'(G_BITS - 1));
  assign Sclk_o     = sclk_q;
  assign Sin_o      = sin_q;

  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    sclk_d  = sclk_q;
    sin_d   = sin_q;
    if (Clear_i) begin
      busy_d  = 1'b0;
      phase_d = '0;
      bit_d   = '0;
      sclk_d  = 1'b0;
      sin_d   = 1'b0;
    end else if (Load_i) begin
      busy_d  = 1'b1;
      phase_d = '0;
      bit_d   = '0;
      sreg_d  = Data_ib;
      sclk_d  = 1'b0;
      sin_d   = Data_ib[G_BITS-1];
    end else if (busy_q) begin
      if (last_phase) begin
        phase_d = '0;
        sclk_d  = 1'b0;
        if (Done_o) begin
          busy_d = 1'b0;
          sin_d  = 1'b0;
        end else begin
          bit_d  = bit_q + 1'b1;
          sreg_d = sreg_q << 1;
          sin_d  = sreg_d[G_BITS-1];
        end
      end else begin
        phase_d = phase_q + 1'b1;
        // sclk is registered, so it rises one phase early in the decode
        sclk_d  = (phase_q >= C_PW'(G_SCLK_HALF - 1));
      end
    end
  end

  always_ff @(posedge Clk_ik) begin
    if (!Rst_irn) begin
      busy_q  <= 1'b0;
      phase_q <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      sclk_q  <= 1'b0;
      sin_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      sclk_q  <= sclk_d;
      sin_q   <= sin_d;
    end
  end

endmodule

// File: rtl/display_scan_driver.sv
// Column-multiplexed LED scan driver: shifts the next column while the current one is lit,
// then blanks, switches csel and latches in the last four cycles of each column slot.
module display_scan_driver
  import display_scan_driver_pkg::*;
#(
  parameter int G_COLUMNS    = C_DEF_COLUMNS,
  parameter int G_BITS       = C_DEF_BITS,
  parameter int G_SCLK_HALF  = C_DEF_SCLK_HALF,
  parameter int G_COL_PERIOD = C_DEF_COL_PERIOD
) (
  input  logic                              Clk_ik,
  input  logic                              Rst_irn,
  input  logic                              Enable_i,
  input  logic [$clog2(G_COL_PERIOD+1)-1:0] Brightness_ib,
  input  logic [G_COLUMNS*G_BITS-1:0]       Frame_ib,
  input  logic                              FrameValid_i,
  output logic                              FrameReady_o,
  output logic                              FrameDone_o,
  t_display.producer                        Display_iot
);

  localparam int C_P  = G_COL_PERIOD;
  localparam int C_S  = shift_cycles(G_BITS, G_SCLK_HALF);
  localparam int C_SW = $clog2(C_P);
  localparam int C_BW = $clog2(C_P + 1);
  localparam int C_CW = (G_COLUMNS > 1) ? $clog2(G_COLUMNS) : 1;

  if (C_P < C_S + C_SWAP_LEN || G_COLUMNS > 8 || G_COLUMNS < 1) begin : g_param_check
    $error("display_scan_driver: column period too short or too many columns");
  end

  t_scan_state                state_q, state_d;
  logic [C_SW-1:0]            slot_q, slot_d;
  logic [C_CW-1:0]            col_q, col_d;
  logic                       first_q, first_d;
  logic                       blank_q, blank_d;
  logic                       latch_q, latch_d;
  logic [2:0]                 csel_q, csel_d;
  logic                       done_q, done_d;
  logic                       ready_q;
  logic                       swap_pend_q;
  logic [G_COLUMNS*G_BITS-1:0] shadow_q, active_q;
  logic                       shift_load, swap_now, shift_done, sclk, sin;
  logic [G_BITS-1:0]          load_data;

  // A pending frame is fed to the shifter directly so column 0 of the new frame is not lost
  assign swap_now  = shift_load && (col_d == '0) && !ready_q;
  assign load_data = swap_now ? shadow_q[G_BITS-1:0] : active_q[int'(col_d)*G_BITS +: G_BITS];

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    col_d      = col_q;
    first_d    = first_q;
    csel_d     = csel_q;
    shift_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Enable_i) begin
          state_d    = ST_SHIFT;
          slot_d     = '0;
          col_d      = '0;
          first_d    = 1'b1;
          shift_load = 1'b1;
        end
      end
      default: begin
        slot_d = (slot_q == C_SW'(C_P - 1)) ? '0 : slot_q + 1'b1;
        if (state_q == ST_SHIFT && shift_done) begin
          state_d = (slot_d >= C_SW'(C_P - C_SWAP_LEN)) ? ST_SWAP : ST_HOLD;
        end else if (state_q == ST_HOLD && slot_d == C_SW'(C_P - C_SWAP_LEN)) begin
          state_d = ST_SWAP;
        end else if (state_q == ST_SWAP && slot_d == '0) begin
          state_d    = ST_SHIFT;
          col_d      = (col_q == C_CW'(G_COLUMNS - 1)) ? '0 : col_q + 1'b1;
          shift_load = 1'b1;
        end
      end
    endcase
    if (!Enable_i) begin
      state_d    = ST_IDLE;
      slot_d     = '0;
      col_d      = '0;
      first_d    = 1'b0;
      csel_d     = '0;
      shift_load = 1'b0;
    end
    latch_d = (state_d == ST_SWAP) && (slot_d == C_SW'(C_P - 2));
    if (state_d == ST_SWAP && slot_d == C_SW'(C_P - 3)) csel_d = 3'(col_q);
    if (latch_d) first_d = 1'b0;
    done_d  = latch_d && (col_q == '0);
    blank_d = (state_d == ST_IDLE) || (state_d == ST_SWAP) || first_d ||
              (C_BW'(slot_d) >= Brightness_ib);
  end

  always_ff @(posedge Clk_ik) begin
    if (!Rst_irn) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      col_q   <= '0;
      first_q <= 1'b0;
      blank_q <= 1'b1;
      latch_q <= 1'b0;
      csel_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      col_q   <= col_d;
      first_q <= first_d;
      blank_q <= blank_d;
      latch_q <= latch_d;
      csel_q  <= csel_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge Clk_ik) begin
    if (!Rst_irn) begin
      shadow_q    <= '0;
      active_q    <= '0;
      ready_q     <= 1'b1;
      swap_pend_q <= 1'b0;
    end else begin
      swap_pend_q <= swap_now;
      if (swap_pend_q) begin
        active_q <= shadow_q;
        ready_q  <= 1'b1;
      end
      if (FrameValid_i && ready_q) begin
        shadow_q <= Frame_ib;
        ready_q  <= 1'b0;
      end
    end
  end

  display_shifter #(
    .G_BITS      (G_BITS),
    .G_SCLK_HALF (G_SCLK_HALF)
  ) u_shifter (
    .Clk_ik  (Clk_ik),
    .Rst_irn (Rst_irn),
    .Clear_i (!Enable_i),
    .Load_i  (shift_load),
    .Data_ib (load_data),
    .Sclk_o  (sclk),
    .Sin_o   (sin),
    .Done_o  (shift_done)
  );

  assign Display_iot.latch = latch_q;
  assign Display_iot.blank = blank_q;
  assign Display_iot.csel  = csel_q;
  assign Display_iot.sclk  = sclk;
  assign Display_iot.sin   = sin;
  assign FrameReady_o      = ready_q;
  assign FrameDone_o       = done_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with 4 columns of 8 bits, sclk half 2, slot 64.
module tb_display_scan_driver;

  localparam int N = 4;
  localparam int B = 8;
  localparam int H = 2;
  localparam int P = 64;
  localparam int S = B * 2 * H;
  localparam logic [31:0] F1 = 32'h01020408;
  localparam logic [31:0] F2 = 32'hA0B0C0D0;
  localparam logic [31:0] F3 = 32'h5A5AA5A5;
  localparam logic [7:0]  IDLE_OUT = 8'h40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fvalid = 1'b0;
  logic [6:0]  bright = 7'd64;
  logic [31:0] frame = 32'h0;
  logic        fready, fdone;
  logic [7:0]  obs;
  int          checks = 0;
  int          passed = 0;

  t_display disp();

  display_scan_driver #(
    .G_COLUMNS(N), .G_BITS(B), .G_SCLK_HALF(H), .G_COL_PERIOD(P)
  ) dut (
    .Clk_ik(clk), .Rst_irn(rst_n), .Enable_i(enable), .Brightness_ib(bright),
    .Frame_ib(frame), .FrameValid_i(fvalid), .FrameReady_o(fready),
    .FrameDone_o(fdone), .Display_iot(disp)
  );

  always #5 clk = ~clk;

  assign obs = {fdone, disp.blank, disp.latch, disp.csel, disp.sclk, disp.sin};

  // Expected {done, blank, latch, csel, sclk, sin} t cycles after the scan starts
  function automatic logic [7:0] model_out(input int t, input logic [31:0] frm, input int brt);
    int slot, s, col;
    logic [7:0] byt;
    logic blank, latch, sclk, sin, done;
    logic [2:0] csel;
    slot  = t % P;
    s     = t / P;
    col   = s % N;
    byt   = frm[col*B +: B];
    sclk  = (slot < S) && ((slot % (2*H)) >= H);
    sin   = (slot < S) ? byt[B-1 - slot/(2*H)] : 1'b0;
    latch = (slot == P-2);
    blank = (s == 0) || (slot >= P-4) || (slot >= brt);
    csel  = (slot >= P-3) ? 3'(col) : ((s == 0) ? 3'd0 : 3'((s-1) % N));
    done  = latch && (col == 0);
    return {done, blank, latch, csel, sclk, sin};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (disp.blank !== 1'b1) $display("FAIL reset_blank got %b want 1", disp.blank); else passed++;
    if (disp.latch !== 1'b0) $display("FAIL reset_latch got %b want 0", disp.latch); else passed++;
    if (disp.csel !== 3'd0) $display("FAIL reset_csel got %0d want 0", disp.csel); else passed++;
    if (disp.sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", disp.sclk); else passed++;
    if (disp.sin !== 1'b0) $display("FAIL reset_sin got %b want 0", disp.sin); else passed++;
    if (fdone !== 1'b0) $display("FAIL reset_done got %b want 0", fdone); else passed++;
    if (fready !== 1'b1) $display("FAIL reset_ready got %b want 1", fready); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_handshake();
    frame = F1; fvalid = 1'b1;
    @(negedge clk);
    fvalid = 1'b0; frame = 32'hFFFF_FFFF;
    checks++;
    if (fready !== 1'b0) $display("FAIL hs_ready_drop got %b want 0", fready); else passed++;
    @(negedge clk);
    checks += 2;
    if (fready !== 1'b0) $display("FAIL hs_ready_hold got %b want 0", fready); else passed++;
    if (obs !== IDLE_OUT) $display("FAIL hs_idle_out got %h want %h", obs, IDLE_OUT); else passed++;
  endtask

  task automatic test_scan();
    logic [7:0] exp;
    bright = 7'd64; enable = 1'b1;
    for (int t = 0; t < 5*P; t++) begin
      @(negedge clk);
      exp = model_out(t, F1, 64);
      checks += 2;
      if (obs !== exp) $display("FAIL scan_out t=%0d got %h want %h", t, obs, exp); else passed++;
      if (fready !== (t >= 1)) $display("FAIL scan_ready t=%0d got %b want %b", t, fready, (t >= 1));
      else passed++;
    end
    bright = 7'd20;
  endtask

  task automatic test_brightness();
    logic [7:0] exp;
    int low = 0;
    for (int t = 5*P; t < 6*P; t++) begin
      @(negedge clk);
      exp = model_out(t, F1, 20);
      checks++;
      if (obs !== exp) $display("FAIL bright_out t=%0d got %h want %h", t, obs, exp); else passed++;
      if (disp.blank === 1'b0) low++;
    end
    checks++;
    if (low !== 20) $display("FAIL bright_low_count got %0d want 20", low); else passed++;
    bright = 7'd64;
  endtask

  task automatic test_new_frame();
    logic [7:0] exp;
    logic       rexp;
    for (int t = 6*P; t < 10*P; t++) begin
      @(negedge clk);
      exp  = model_out(t, (t >= 8*P) ? F2 : F1, 64);
      rexp = !(t >= 6*P+11 && t <= 8*P);
      checks += 2;
      if (obs !== exp) $display("FAIL newf_out t=%0d got %h want %h", t, obs, exp); else passed++;
      if (fready !== rexp) $display("FAIL newf_ready t=%0d got %b want %b", t, fready, rexp);
      else passed++;
      if (t == 6*P+10) begin frame = F2; fvalid = 1'b1; end
      else if (t == 6*P+11) begin fvalid = 1'b0; frame = 32'hFFFF_FFFF; end
      else if (t == 7*P+2) begin frame = F3; fvalid = 1'b1; end
      else if (t == 7*P+3) fvalid = 1'b0;
    end
  endtask

  task automatic test_disable();
    logic [7:0] exp;
    for (int t = 10*P; t <= 10*P+10; t++) begin
      @(negedge clk);
      exp = model_out(t, F2, 64);
      checks++;
      if (obs !== exp) $display("FAIL dis_pre t=%0d got %h want %h", t, obs, exp); else passed++;
    end
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks += 2;
      if (obs !== IDLE_OUT) $display("FAIL dis_idle k=%0d got %h want %h", k, obs, IDLE_OUT); else passed++;
      if (fready !== 1'b1) $display("FAIL dis_ready k=%0d got %b want 1", k, fready); else passed++;
    end
  endtask

  task automatic test_reenable();
    logic [7:0] exp;
    enable = 1'b1;
    for (int t = 0; t <= P+60; t++) begin
      @(negedge clk);
      exp = model_out(t, F2, 64);
      checks += 2;
      if (obs !== exp) $display("FAIL reen_out t=%0d got %h want %h", t, obs, exp); else passed++;
      if (fready !== (t <= 5)) $display("FAIL reen_ready t=%0d got %b want %b", t, fready, (t <= 5));
      else passed++;
      if (t == 5) begin frame = F3; fvalid = 1'b1; end
      else if (t == 6) fvalid = 1'b0;
    end
    rst_n = 1'b0;
  endtask

  task automatic test_reset_swap();
    logic [7:0] exp;
    @(negedge clk);
    checks += 2;
    if (obs !== IDLE_OUT) $display("FAIL rswap_out got %h want %h", obs, IDLE_OUT); else passed++;
    if (fready !== 1'b1) $display("FAIL rswap_ready got %b want 1", fready); else passed++;
    rst_n = 1'b1;
    for (int t = 0; t < P; t++) begin
      @(negedge clk);
      exp = model_out(t, 32'h0, 64);
      checks++;
      if (obs !== exp) $display("FAIL rswap_cleared t=%0d got %h want %h", t, obs, exp); else passed++;
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_scan();
    test_brightness();
    test_new_frame();
    test_disable();
    test_reenable();
    test_reset_swap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
